// File: rtl/piso_tx_pkg.sv
// ----------------------------------------------------------------------------
// piso_tx_pkg
// Shared definitions for the parallel-in / serial-out framed transmitter:
//   - tx_state_t   : frame sequencer states
//   - cnt_w()      : counter width helper, max(1, clog2(n))
//   - frame_clks() : clocks from handshake edge to the STOP->IDLE edge
// ----------------------------------------------------------------------------
package piso_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // A counter over n values never needs fewer than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Start + data + optional parity + stop, each held baud_div clocks.
    function automatic int frame_clks(input int data_w, input int baud_div, input int parity_en);
        return (2 + data_w + parity_en) * baud_div;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
// Free-running 0..BAUD_DIV-1 counter producing a one-cycle bit-end tick.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset (counter -> 0)
//   clr  in  restart the count at 0 (asserted on the frame handshake)
//   tick out high while the counter sits at BAUD_DIV-1, i.e. the edge that
//            ends the current serial bit
// ----------------------------------------------------------------------------
module baud_tick_gen
    import piso_tx_pkg::*;
#(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_w(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    // With BAUD_DIV=1 the counter is stuck at 0 == LAST, so every edge ticks.
    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// ----------------------------------------------------------------------------
// piso_serial_tx
// Framed parallel-in / serial-out transmitter: start(0), data, optional
// parity, stop(1); each bit held BAUD_DIV clocks. Line idles high.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset; aborts any frame
//   tx_data   in   word to send, captured on the valid/ready handshake edge
//   tx_valid  in   producer has a word
//   tx_ready  out  transmitter idle and not in reset (combinational)
//   sd        out  registered serial data line
//   busy      out  frame in progress
//   done      out  one-cycle pulse after the stop bit completes
// ----------------------------------------------------------------------------
module piso_serial_tx
    import piso_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int MSB_FIRST  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sd,
    output logic              busy,
    output logic              done
);

    localparam int BIT_CW = cnt_w(DATA_W);
    localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(DATA_W - 1);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_CW-1:0] r_bit_cnt;
    logic              r_parity;
    logic              r_sd;
    logic              r_done;

    logic [DATA_W-1:0] w_shift_next;
    logic              w_first_bit;
    logic              w_next_bit;
    logic              w_tick;
    logic              w_handshake;

    assign tx_ready    = (r_state == IDLE) && !rst;
    assign w_handshake = tx_valid && tx_ready;
    assign sd          = r_sd;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;

    // The bit on the line is always taken from the outgoing end of the
    // shift register; the direction of shift picks LSB- or MSB-first.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = r_shift << 1;
            assign w_first_bit  = r_shift[DATA_W-1];
            assign w_next_bit   = w_shift_next[DATA_W-1];
        end else begin : g_lsb_first
            assign w_shift_next = r_shift >> 1;
            assign w_first_bit  = r_shift[0];
            assign w_next_bit   = w_shift_next[0];
        end
    endgenerate

    // Handshake restarts the baud count so the start bit lasts a full period.
    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_handshake),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_sd      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_shift   <= tx_data;
                        r_parity  <= (^tx_data) ^ 1'(PARITY_ODD);
                        r_bit_cnt <= '0;
                        r_sd      <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_sd    <= w_first_bit;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_sd    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_sd    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_shift   <= w_shift_next;
                            r_sd      <= w_next_bit;
                            r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_sd    <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_sd    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_piso_serial_tx
// Four transmitter instances with different framing parameters share clock,
// reset and data; each has its own valid. A per-instance reference model
// turns each accepted word into its list of line bits and predicts sd, busy,
// done and tx_ready every cycle. Directed frames check literal bit patterns
// and frame lengths; then random words with random gaps (including
// handshakes in the done cycle) and random data churn while busy.
// ----------------------------------------------------------------------------
module tb_piso_serial_tx;

    localparam int NDUT = 4;
    localparam int DW_A [NDUT] = '{8, 8, 8, 5};
    localparam int BD_A [NDUT] = '{4, 4, 1, 3};
    localparam int PE_A [NDUT] = '{0, 1, 0, 1};
    localparam int PO_A [NDUT] = '{0, 0, 0, 1};
    localparam int MF_A [NDUT] = '{0, 0, 1, 0};

    logic            clk;
    logic            rst;
    logic [7:0]      tx_data;
    logic [NDUT-1:0] tx_valid;
    logic [NDUT-1:0] ready_a;
    logic [NDUT-1:0] sd_a;
    logic [NDUT-1:0] busy_a;
    logic [NDUT-1:0] done_a;
    int              dones_a    [NDUT];
    int              exp_frames [NDUT];

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int DW = DW_A[gi];
        localparam int BD = BD_A[gi];
        localparam int PE = PE_A[gi];
        localparam int PO = PO_A[gi];
        localparam int MF = MF_A[gi];

        piso_serial_tx #(
            .DATA_W     (DW),
            .BAUD_DIV   (BD),
            .PARITY_EN  (PE),
            .PARITY_ODD (PO),
            .MSB_FIRST  (MF)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .tx_data  (tx_data[DW-1:0]),
            .tx_valid (tx_valid[gi]),
            .tx_ready (ready_a[gi]),
            .sd       (sd_a[gi]),
            .busy     (busy_a[gi]),
            .done     (done_a[gi])
        );

        // Model: k = clocks since the accepting edge (-1 when idle); the
        // line shows bits[k / BD] while a frame is active.
        int   k         = -1;
        bit   bits[$];
        bit   done_m    = 1'b0;
        bit   armed     = 1'b0;
        int   done_seen = 0;

        assign dones_a[gi] = done_seen;

        always @(posedge clk) begin
            logic [7:0] w;
            armed  = 1'b1;
            done_m = 1'b0;
            if (rst) begin
                k = -1;
            end else if (k < 0) begin
                if (tx_valid[gi]) begin
                    w = tx_data;
                    bits.delete();
                    bits.push_back(1'b0);
                    for (int b = 0; b < DW; b++)
                        bits.push_back((MF != 0) ? w[DW-1-b] : w[b]);
                    if (PE != 0)
                        bits.push_back(1'(($countones(w[DW-1:0]) + PO) % 2));
                    bits.push_back(1'b1);
                    k = 0;
                end
            end else begin
                k++;
                if (k == bits.size() * BD) begin
                    k      = -1;
                    done_m = 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            #1;
            if (armed) begin
                chk($sformatf("d%0d_sd", gi), 32'(sd_a[gi]), (k >= 0) ? 32'(bits[k / BD]) : 32'd1);
                chk($sformatf("d%0d_busy", gi), 32'(busy_a[gi]), 32'(k >= 0));
                chk($sformatf("d%0d_done", gi), 32'(done_a[gi]), 32'(done_m));
                chk($sformatf("d%0d_ready", gi), 32'(ready_a[gi]), 32'((k < 0) && !rst));
                if (done_a[gi]) done_seen++;
            end
        end
    end

    // Present a word and return just after the (expected) handshake edge.
    task automatic send(input int idx, input logic [7:0] w);
        int n = 0;
        while (!ready_a[idx] && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_data       = w;
        tx_valid[idx] = 1'b1;
        $display("tx dut%0d data=%02h", idx, w);
        @(posedge clk);
    endtask

    // Follow a frame to its done pulse, sampling each bit mid-period.
    task automatic wait_done(input int idx, input string tag, output logic [15:0] got);
        int bd   = BD_A[idx];
        int flen = piso_tx_pkg::frame_clks(DW_A[idx], BD_A[idx], PE_A[idx]);
        int kd   = -1;
        got = '0;
        for (int kk = 0; kk < 600 && kd < 0; kk++) begin
            @(negedge clk);
            if (kk == 0) tx_valid[idx] = 1'b0;
            else         tx_data = 8'($urandom);
            if (done_a[idx]) kd = kk;
            else if ((kk % bd) == bd / 2 && kk / bd < 16) got[kk / bd] = sd_a[idx];
        end
        chk({tag, "_len"}, kd, flen);
        exp_frames[idx]++;
    endtask

    task automatic directed(input int idx, input logic [7:0] w, input logic [15:0] exp_bits, input string tag);
        logic [15:0] got;
        send(idx, w);
        wait_done(idx, tag, got);
        chk({tag, "_bits"}, got, exp_bits);
    endtask

    initial begin
        logic [15:0] got;
        int kd;
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        tx_valid = '0;
        tx_data  = '0;
        for (int i = 0; i < NDUT; i++) exp_frames[i] = 0;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle with no valid: line stays high, nothing completes.
        repeat (20) @(negedge clk);
        chk("idle_done_cnt", dones_a[0] + dones_a[1] + dones_a[2] + dones_a[3], 0);

        // Bit i of each pattern is the i-th bit on the line in time.
        directed(0, 8'hA5, 16'b0000001101001010, "a5");
        directed(1, 8'h07, 16'b0000011000001110, "even07");
        directed(2, 8'h81, 16'b0000001100000010, "msb81");
        directed(3, 8'h07, 16'b0000000010001110, "odd07");

        // Back-to-back with valid held high; data churn mid-frame.
        @(negedge clk);
        chk("b2b_ready0", 32'(ready_a[0]), 1);
        tx_data     = 8'h11;
        tx_valid[0] = 1'b1;
        $display("tx dut0 data=11 (valid held)");
        @(posedge clk);
        kd = -1;
        for (int kk = 0; kk < 200 && kd < 0; kk++) begin
            @(negedge clk);
            if (kk == 10) tx_data = 8'hFF;
            if (kk == 30) tx_data = 8'h22;
            if (done_a[0]) kd = kk;
        end
        chk("b2b_len1", kd, piso_tx_pkg::frame_clks(8, 4, 0));
        chk("b2b_ready_in_done", 32'(ready_a[0]), 1);
        chk("b2b_gap_sd", 32'(sd_a[0]), 1);
        exp_frames[0]++;
        $display("tx dut0 data=22 (handshake in done cycle)");
        @(posedge clk);
        wait_done(0, "b2b2", got);

        // Reset during the third data bit aborts the frame.
        @(negedge clk);
        send(0, 8'h3C);
        for (int kk = 0; kk < 14; kk++) begin
            @(negedge clk);
            if (kk == 0) tx_valid[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sd", 32'(sd_a[0]), 1);
        chk("rst_busy", 32'(busy_a[0]), 0);
        chk("rst_done", 32'(done_a[0]), 0);
        chk("rst_ready", 32'(ready_a[0]), 1);
        repeat (60) @(negedge clk);
        directed(0, 8'hA5, 16'b0000001101001010, "after_rst");

        // Random words, random gaps (gap 0 = handshake in the done cycle).
        for (int i = 0; i < NDUT; i++) begin
            for (int f = 0; f < 12; f++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(i, 8'($urandom));
                wait_done(i, $sformatf("rnd%0d", i), got);
            end
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            chk($sformatf("done_cnt%0d", i), dones_a[i], exp_frames[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
